// File: rtl/ethernet_receive_que_pkg.sv
// Shared constants and types for the Ethernet receive queue and related CRC logic.
package ethernet_receive_que_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    localparam int unsigned DEFAULT_MIN_FRAME_BYTES = 64;
    localparam int unsigned DEFAULT_MAX_FRAME_BYTES = 1522;
    localparam int unsigned FCS_BYTES               = 4;
    localparam int unsigned FRAME_LEN_WIDTH         = 11;
    localparam int unsigned DROP_COUNT_WIDTH        = 16;

    typedef enum logic [1:0] {
        IDLE,
        RECEIVE,
        VERDICT,
        DRAIN
    } receive_que_state;

endpackage

// File: rtl/ethernet_receive_que_if.sv
// MAC-side receive stream and pusher-side replay stream of one receive queue slot.
interface ethernet_receive_que_if;
    import ethernet_receive_que_pkg::*;

    logic [7:0]                  receive_data;
    logic                        receive_data_valid;
    logic                        receive_error;
    logic                        packet_data_ready;
    logic                        good_packet;
    logic                        bad_packet;
    logic [7:0]                  packet_data;
    logic                        packet_data_enable;
    logic [FRAME_LEN_WIDTH-1:0]  frame_length;
    logic [DROP_COUNT_WIDTH-1:0] dropped_frame_count;

    modport slave (
        input  receive_data,
        input  receive_data_valid,
        input  receive_error,
        input  packet_data_ready,
        output good_packet,
        output bad_packet,
        output packet_data,
        output packet_data_enable,
        output frame_length,
        output dropped_frame_count
    );

    modport master (
        output receive_data,
        output receive_data_valid,
        output receive_error,
        output packet_data_ready,
        input  good_packet,
        input  bad_packet,
        input  packet_data,
        input  packet_data_enable,
        input  frame_length,
        input  dropped_frame_count
    );

endinterface

// File: rtl/ethernet_receive_que_crc32_byte.sv
// Combinational one-byte step of the reflected Ethernet CRC-32 (LSB first).
module ethernet_receive_que_crc32_byte
    import ethernet_receive_que_pkg::*;
(
    input  logic [31:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);

    logic [31:0] w_crc;

    always_comb begin
        w_crc = i_crc ^ {24'h000000, i_data};
        for (int i = 0; i < 8; i++) begin
            w_crc = w_crc[0] ? ((w_crc >> 1) ^ CRC32_POLY) : (w_crc >> 1);
        end
        o_crc = w_crc;
    end

endmodule

// File: rtl/ethernet_receive_que.sv
// Single-frame receive buffer: captures a frame, checks FCS and length, replays good payload.
module ethernet_receive_que
    import ethernet_receive_que_pkg::*;
#(
    parameter int unsigned BUFFER_DEPTH    = 2048,
    parameter int unsigned MIN_FRAME_BYTES = DEFAULT_MIN_FRAME_BYTES,
    parameter int unsigned MAX_FRAME_BYTES = DEFAULT_MAX_FRAME_BYTES
) (
    input logic                   clock,
    input logic                   reset,
    ethernet_receive_que_if.slave bus
);

    localparam int unsigned ADDR_WIDTH = $clog2(BUFFER_DEPTH);
    localparam logic [FRAME_LEN_WIDTH-1:0] MIN_COUNT = FRAME_LEN_WIDTH'(MIN_FRAME_BYTES);
    localparam logic [FRAME_LEN_WIDTH-1:0] MAX_COUNT = FRAME_LEN_WIDTH'(MAX_FRAME_BYTES);
    localparam logic [FRAME_LEN_WIDTH-1:0] FCS_COUNT = FRAME_LEN_WIDTH'(FCS_BYTES);

    receive_que_state r_state;
    receive_que_state w_state_next;

    logic [7:0]                  r_mem [BUFFER_DEPTH];
    logic                        r_valid_prev;
    logic [FRAME_LEN_WIDTH-1:0]  r_count;
    logic [FRAME_LEN_WIDTH-1:0]  r_remaining;
    logic [FRAME_LEN_WIDTH-1:0]  r_frame_length;
    logic [ADDR_WIDTH-1:0]       r_wr_ptr;
    logic [ADDR_WIDTH-1:0]       r_rd_ptr;
    logic [31:0]                 r_crc;
    logic                        r_error;
    logic                        r_oversize;
    logic                        r_good_packet;
    logic                        r_bad_packet;
    logic                        r_packet_data_enable;
    logic [7:0]                  r_packet_data;
    logic [DROP_COUNT_WIDTH-1:0] r_dropped;

    logic                  w_rise;
    logic                  w_start;
    logic                  w_capture;
    logic                  w_judge;
    logic                  w_rd_en;
    logic                  w_finish;
    logic                  w_drop;
    logic                  w_xfer;
    logic                  w_full;
    logic                  w_frame_ok;
    logic                  w_wr_en;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic [31:0]           w_crc_next;

    ethernet_receive_que_crc32_byte u_crc (
        .i_crc  (r_crc),
        .i_data (bus.receive_data),
        .o_crc  (w_crc_next)
    );

    assign w_rise     = bus.receive_data_valid & ~r_valid_prev;
    assign w_xfer     = r_packet_data_enable & bus.packet_data_ready;
    assign w_full     = (r_count >= MAX_COUNT);
    assign w_frame_ok = ~r_error & ~r_oversize & (r_count >= MIN_COUNT) &
                        (r_crc == CRC32_RESIDUE);
    assign w_wr_en    = w_start | (w_capture & ~w_full);
    assign w_wr_addr  = w_start ? '0 : r_wr_ptr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_capture    = 1'b0;
        w_judge      = 1'b0;
        w_rd_en      = 1'b0;
        w_finish     = 1'b0;
        w_drop       = 1'b0;
        w_rd_addr    = r_rd_ptr;
        unique case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_start      = 1'b1;
                    w_state_next = RECEIVE;
                end
            end
            RECEIVE: begin
                if (bus.receive_data_valid) begin
                    w_capture = 1'b1;
                end else begin
                    w_judge      = 1'b1;
                    w_state_next = VERDICT;
                end
            end
            VERDICT: begin
                w_drop = w_rise;
                if (r_good_packet) begin
                    w_rd_en      = 1'b1;
                    w_rd_addr    = '0;
                    w_state_next = DRAIN;
                end else begin
                    w_state_next = IDLE;
                end
            end
            DRAIN: begin
                w_drop = w_rise;
                if (w_xfer) begin
                    if (r_remaining == FRAME_LEN_WIDTH'(1)) begin
                        w_finish     = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_rd_en = 1'b1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Valid history resets high so a frame already in flight at reset is never captured.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid_prev         <= 1'b1;
            r_count              <= '0;
            r_remaining          <= '0;
            r_frame_length       <= '0;
            r_wr_ptr             <= '0;
            r_rd_ptr             <= '0;
            r_crc                <= CRC32_INIT;
            r_error              <= 1'b0;
            r_oversize           <= 1'b0;
            r_good_packet        <= 1'b0;
            r_bad_packet         <= 1'b0;
            r_packet_data_enable <= 1'b0;
            r_packet_data        <= '0;
            r_dropped            <= '0;
        end else begin
            r_valid_prev <= bus.receive_data_valid;

            if (w_start) begin
                r_count    <= FRAME_LEN_WIDTH'(1);
                r_wr_ptr   <= ADDR_WIDTH'(1);
                r_crc      <= w_crc_next;
                r_error    <= bus.receive_error;
                r_oversize <= 1'b0;
            end else if (w_capture) begin
                r_crc <= w_crc_next;
                if (bus.receive_error) begin
                    r_error <= 1'b1;
                end
                if (w_full) begin
                    r_oversize <= 1'b1;
                end else begin
                    r_count  <= r_count + FRAME_LEN_WIDTH'(1);
                    r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
                end
            end else if (w_judge) begin
                r_crc <= CRC32_INIT;
            end

            r_bad_packet <= w_judge & ~w_frame_ok;
            if (w_judge) begin
                r_good_packet <= w_frame_ok;
                if (w_frame_ok) begin
                    r_frame_length <= r_count - FCS_COUNT;
                    r_remaining    <= r_count - FCS_COUNT;
                end
            end else if (w_finish) begin
                r_good_packet  <= 1'b0;
                r_frame_length <= '0;
            end

            // Read data register doubles as the output byte, so it only moves on a transfer.
            if (w_rd_en) begin
                r_packet_data        <= r_mem[w_rd_addr];
                r_rd_ptr             <= w_rd_addr + ADDR_WIDTH'(1);
                r_packet_data_enable <= 1'b1;
            end else if (w_finish) begin
                r_packet_data_enable <= 1'b0;
            end

            if (w_xfer && (r_state == DRAIN)) begin
                r_remaining <= r_remaining - FRAME_LEN_WIDTH'(1);
            end

            if (w_drop && (r_dropped != '1)) begin
                r_dropped <= r_dropped + DROP_COUNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= bus.receive_data;
        end
    end

    assign bus.good_packet         = r_good_packet;
    assign bus.bad_packet          = r_bad_packet;
    assign bus.packet_data         = r_packet_data;
    assign bus.packet_data_enable  = r_packet_data_enable;
    assign bus.frame_length        = r_frame_length;
    assign bus.dropped_frame_count = r_dropped;

endmodule

// File: tb/tb_ethernet_receive_que.sv
// Scoreboard bench: stimulus queues expected verdicts/bytes, a negedge monitor checks them.
module tb_ethernet_receive_que;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        bit good;
        int len;
    } verdict_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    ethernet_receive_que_if bus ();

    ethernet_receive_que #(
        .BUFFER_DEPTH    (2048),
        .MIN_FRAME_BYTES (64),
        .MAX_FRAME_BYTES (1522)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        forever #5 clock = ~clock;
    end

    int       n_compared = 0;
    int       n_mismatch = 0;
    verdict_t exp_verdict[$];
    byte_q_t  exp_bytes;
    byte_q_t  tx_payload;
    int       rdy_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_compared++;
        if (act !== req) begin
            n_mismatch++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] fcs32(input byte_q_t d);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (d[i]) begin
            c = c ^ {24'h000000, d[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Frame = random payload + FCS; the model decides the verdict from the frame rules.
    task automatic send_frame(input int total, input bit corrupt, input int err_idx);
        logic [31:0] fcs;
        bit          ok;
        verdict_t    v;
        tx_payload.delete();
        for (int i = 0; i < total - 4; i++) tx_payload.push_back(8'($urandom));
        fcs = fcs32(tx_payload);
        if (corrupt) tx_payload[10] = tx_payload[10] ^ 8'h01;
        ok = (err_idx < 0) && (total >= 64) && (total <= 1522) && (fcs32(tx_payload) == fcs);
        v.good = ok;
        v.len  = total - 4;
        exp_verdict.push_back(v);
        if (ok) foreach (tx_payload[i]) exp_bytes.push_back(tx_payload[i]);
        for (int i = 0; i < total; i++) begin
            tick();
            bus.receive_data       = (i < total - 4) ? tx_payload[i] : fcs[8*(i-(total-4)) +: 8];
            bus.receive_data_valid = 1'b1;
            bus.receive_error      = (i == err_idx);
        end
        tick();
        bus.receive_data_valid = 1'b0;
        bus.receive_error      = 1'b0;
        bus.receive_data       = 8'h00;
    endtask

    task automatic drive_raw(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            bus.receive_data       = 8'($urandom);
            bus.receive_data_valid = 1'b1;
            bus.receive_error      = 1'b0;
        end
        tick();
        bus.receive_data_valid = 1'b0;
        bus.receive_data       = 8'h00;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        repeat (4) tick();
        while ((bus.good_packet || bus.packet_data_enable) && n < 8000) begin
            tick();
            n++;
        end
        if (n >= 8000) begin
            n_compared++;
            n_mismatch++;
            $display("FAIL wait_idle: drain still busy after %0d cycles", n);
        end
        repeat (2) tick();
    endtask

    initial begin
        bus.packet_data_ready = 1'b1;
        forever begin
            tick();
            case (rdy_mode)
                1:       bus.packet_data_ready = ~bus.packet_data_ready;
                2:       bus.packet_data_ready = 1'($urandom_range(0, 1));
                default: bus.packet_data_ready = 1'b1;
            endcase
        end
    end

    // Monitor
    initial begin
        int       cyc;
        int       fall_cyc;
        int       good_cyc;
        int       last_xfer_cyc;
        int       frame_left;
        logic     prev_good, prev_bad, prev_en, prev_rdy, prev_valid;
        logic [7:0] prev_data;
        verdict_t v;
        cyc = 0; fall_cyc = -10; good_cyc = -10; last_xfer_cyc = -10; frame_left = 0;
        prev_good = 0; prev_bad = 0; prev_en = 0; prev_rdy = 0; prev_valid = 0; prev_data = 0;
        forever begin
            @(negedge clock);
            cyc++;
            if (reset) begin
                exp_verdict.delete();
                exp_bytes.delete();
                frame_left = 0;
                prev_good = 0; prev_bad = 0; prev_en = 0; prev_rdy = 0;
                prev_valid = bus.receive_data_valid;
            end else begin
                if (bus.good_packet || bus.bad_packet)
                    chk("good_bad_exclusive", 32'(bus.good_packet & bus.bad_packet), 0);
                if (bus.bad_packet) begin
                    chk("bad_pulse_width", 32'(prev_bad), 0);
                    if (!prev_bad) begin
                        chk("bad_verdict_expected", 32'(exp_verdict.size() != 0), 1);
                        if (exp_verdict.size() != 0) begin
                            v = exp_verdict.pop_front();
                            chk("verdict_bad", 32'(v.good), 0);
                            chk("bad_timing", 32'(cyc), 32'(fall_cyc + 1));
                            if (v.good) repeat (v.len) if (exp_bytes.size() != 0)
                                void'(exp_bytes.pop_front());
                        end
                    end
                end
                if (bus.good_packet && !prev_good) begin
                    chk("good_verdict_expected", 32'(exp_verdict.size() != 0), 1);
                    if (exp_verdict.size() != 0) begin
                        v = exp_verdict.pop_front();
                        chk("verdict_good", 32'(v.good), 1);
                        chk("frame_length", 32'(bus.frame_length), 32'(v.len));
                    end
                    chk("good_timing", 32'(cyc), 32'(fall_cyc + 1));
                    frame_left = int'(bus.frame_length);
                    good_cyc   = cyc;
                end
                if (bus.packet_data_enable) chk("enable_needs_good", 32'(bus.good_packet), 1);
                if (bus.packet_data_enable && !prev_en)
                    chk("enable_rise_timing", 32'(cyc), 32'(good_cyc + 1));
                if (prev_en && !prev_rdy) begin
                    chk("stall_enable_held", 32'(bus.packet_data_enable), 1);
                    chk("stall_data_stable", 32'(bus.packet_data), 32'(prev_data));
                end
                if (bus.packet_data_enable && bus.packet_data_ready) begin
                    chk("no_extra_byte", 32'(frame_left != 0), 1);
                    if (frame_left != 0 && exp_bytes.size() != 0)
                        chk("packet_data", 32'(bus.packet_data), 32'(exp_bytes.pop_front()));
                    frame_left--;
                    last_xfer_cyc = cyc;
                end
                if (!bus.good_packet && prev_good) begin
                    chk("good_fall_bytes_left", 32'(frame_left), 0);
                    chk("good_fall_timing", 32'(cyc), 32'(last_xfer_cyc + 1));
                    chk("enable_fall", 32'(bus.packet_data_enable), 0);
                end
                if (prev_valid && !bus.receive_data_valid) fall_cyc = cyc;
                prev_good  = bus.good_packet;
                prev_bad   = bus.bad_packet;
                prev_en    = bus.packet_data_enable;
                prev_rdy   = bus.packet_data_ready;
                prev_data  = bus.packet_data;
                prev_valid = bus.receive_data_valid;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.receive_data       = 8'h00;
        bus.receive_data_valid = 1'b0;
        bus.receive_error      = 1'b0;
        repeat (3) @(posedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        chk("reset_good", 32'(bus.good_packet), 0);
        chk("reset_bad", 32'(bus.bad_packet), 0);
        chk("reset_enable", 32'(bus.packet_data_enable), 0);
        chk("reset_data", 32'(bus.packet_data), 0);
        chk("reset_length", 32'(bus.frame_length), 0);
        chk("reset_dropped", 32'(bus.dropped_frame_count), 0);

        rdy_mode = 0;
        send_frame(64, 1'b0, -1);   wait_idle();
        send_frame(64, 1'b1, -1);   wait_idle();
        send_frame(40, 1'b0, -1);   wait_idle();
        send_frame(1600, 1'b0, -1); wait_idle();
        send_frame(1522, 1'b0, -1); wait_idle();
        send_frame(100, 1'b0, 50);  wait_idle();
        rdy_mode = 1;
        send_frame(128, 1'b0, -1);  wait_idle();
        rdy_mode = 0;

        // Second frame arrives while the first is draining.
        send_frame(64, 1'b0, -1);
        repeat (5) tick();
        drive_raw(100);
        wait_idle();
        chk("dropped_count", 32'(bus.dropped_frame_count), 1);
        send_frame(80, 1'b0, -1);   wait_idle();
        chk("dropped_count_held", 32'(bus.dropped_frame_count), 1);

        // Reset during drain while another frame is on the wire.
        send_frame(128, 1'b0, -1);
        fork
            begin
                repeat (20) tick();
                drive_raw(80);
            end
            begin
                repeat (40) tick();
                #1 reset = 1'b1;
                #1;
                chk("async_reset_good", 32'(bus.good_packet), 0);
                chk("async_reset_bad", 32'(bus.bad_packet), 0);
                chk("async_reset_enable", 32'(bus.packet_data_enable), 0);
                chk("async_reset_data", 32'(bus.packet_data), 0);
                chk("async_reset_length", 32'(bus.frame_length), 0);
                chk("async_reset_dropped", 32'(bus.dropped_frame_count), 0);
                repeat (3) @(posedge clock);
                #2 reset = 1'b0;
            end
        join
        wait_idle();
        send_frame(64, 1'b0, -1);   wait_idle();
        chk("dropped_after_reset", 32'(bus.dropped_frame_count), 0);

        for (int i = 0; i < 25; i++) begin
            int len;
            int sel;
            int err;
            bit corrupt;
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      len = int'($urandom_range(30, 63));
            else if (sel == 1) len = int'($urandom_range(1500, 1560));
            else               len = int'($urandom_range(64, 300));
            corrupt  = ($urandom_range(0, 5) == 0);
            err      = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            rdy_mode = int'($urandom_range(0, 2));
            send_frame(len, corrupt, err);
            wait_idle();
        end

        rdy_mode = 0;
        repeat (5) tick();
        chk("verdicts_drained", 32'(exp_verdict.size()), 0);
        chk("bytes_drained", 32'(exp_bytes.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
